// File: rtl/cordic_pkg.sv
// Shared types and constants for the float CORDIC
// custom-instruction front ends.
package cordic_pkg;

  localparam int LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    OP_COS    = 2'd0,
    OP_LAST   = 2'd1,
    OP_OPCNT  = 2'd2,
    OP_ERRCNT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [7:0]  HALF_PI_EXP  = 8'd127;
  localparam logic [22:0] HALF_PI_MANT = 23'h490FDB;

endpackage

// File: rtl/cordic_ci_ctrl_if.sv
// CPU custom-instruction and CORDIC core signals
// bundled for the front end.
interface cordic_ci_ctrl_if #(
  parameter int W = 32
);
  logic         clk_en;
  logic         start;
  logic [1:0]   n;
  logic [W-1:0] dataa;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] cordic_dataa;
  logic [W-1:0] cordic_result;

  modport master (
    output clk_en, start, n, dataa,
    output cordic_result,
    input  done, result, cordic_dataa
  );

  modport slave (
    input  clk_en, start, n, dataa,
    input  cordic_result,
    output done, result, cordic_dataa
  );
endinterface

// File: rtl/cordic_arg_check.sv
// Range check of a folded float magnitude
// against pi/2; Inf/NaN fall out as too large.
module cordic_arg_check
  import cordic_pkg::*;
(
  input  logic [30:0] i_mag,
  output logic        o_in_range
);

  logic [7:0]  w_exp;
  logic [22:0] w_mant;

  assign w_exp  = i_mag[30:23];
  assign w_mant = i_mag[22:0];

  always_comb begin
    o_in_range = 1'b1;
    if (w_exp > HALF_PI_EXP)
      o_in_range = 1'b0;
    else if (w_exp == HALF_PI_EXP &&
             w_mant > HALF_PI_MANT)
      o_in_range = 1'b0;
  end

endmodule

// File: rtl/cordic_ci_ctrl.sv
// Nios II multi-cycle custom-instruction front end
// for the pipelined float cosine CORDIC core.
module cordic_ci_ctrl
  import cordic_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int W       = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cordic_ci_ctrl_if.slave  bus
);

  localparam int CW = $clog2(LATENCY + 1);

  state_e             r_state;
  state_e             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nx;
  logic               r_done;
  logic               w_done_nx;
  logic [W-1:0]       r_result;
  logic [W-1:0]       w_result_nx;
  logic [W-1:0]       r_cdata;
  logic [W-1:0]       w_cdata_nx;
  logic [W-1:0]       r_last;
  logic [W-1:0]       w_last_nx;
  logic [CNT_W-1:0]   r_op_cnt;
  logic [CNT_W-1:0]   w_op_cnt_nx;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   w_err_cnt_nx;

  op_e                w_op;
  logic               w_cos;
  logic               w_ok;

  assign w_op  = op_e'(bus.n);
  assign w_cos = (w_op == OP_COS);

  cordic_arg_check u_chk (
    .i_mag      (bus.dataa[30:0]),
    .o_in_range (w_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else if (bus.clk_en)
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_done_nx    = 1'b0;
    w_result_nx  = r_result;
    w_cdata_nx   = r_cdata;
    w_last_nx    = r_last;
    w_op_cnt_nx  = r_op_cnt;
    w_err_cnt_nx = r_err_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_DONE;
          unique case (1'b1)
            w_cos && w_ok: begin
              w_done_nx  = 1'b0;
              w_state_nx = S_WAIT;
              w_cnt_nx   = CW'(LATENCY);
              w_cdata_nx = {1'b0, bus.dataa[W-2:0]};
            end
            w_cos && !w_ok: begin
              w_result_nx  = QNAN;
              w_err_cnt_nx = r_err_cnt + CNT_W'(1);
            end
            w_op == OP_LAST:
              w_result_nx = r_last;
            w_op == OP_OPCNT:
              w_result_nx = W'(r_op_cnt);
            w_op == OP_ERRCNT:
              w_result_nx = W'(r_err_cnt);
          endcase
        end
      end
      S_WAIT: begin
        // core input has been stable long enough
        if (r_cnt == CW'(1)) begin
          w_result_nx = bus.cordic_result;
          w_last_nx   = bus.cordic_result;
          w_op_cnt_nx = r_op_cnt + CNT_W'(1);
          w_done_nx   = 1'b1;
          w_state_nx  = S_DONE;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_DONE:
        w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_cdata   <= '0;
      r_last    <= '0;
      r_op_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (bus.clk_en) begin
      r_cnt     <= w_cnt_nx;
      r_done    <= w_done_nx;
      r_result  <= w_result_nx;
      r_cdata   <= w_cdata_nx;
      r_last    <= w_last_nx;
      r_op_cnt  <= w_op_cnt_nx;
      r_err_cnt <= w_err_cnt_nx;
    end
  end

  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.cordic_dataa = r_cdata;

endmodule

// File: doc/cordic_ci_ctrl.md
Name: cordic_ci_ctrl

Overview:
Nios II multi-cycle custom-instruction front end for the pipelined float cosine CORDIC core.
- Upstream side: accepts the CPU handshake (start/dataa/n/clk_en).
- Core side: folds the argument to |a|, range-checks it, holds it stable on the core input, waits out the core's fixed pipeline latency, then captures the float result and pulses done.
- Also provides read-back of the last result and operation/error counters through the n field.

Parameters:
LATENCY, 4, clock edges from a stable core input to a valid core result (core pipeline depth)
W, 32, float/data width (IEEE-754 single)
CNT_W, 32, width of op and error counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
clk_en  in  1  CPU clock enable; when low, FSM, counters and outputs hold
start  in  1  one-cycle request, qualified by clk_en
n  in  2  opcode: 0 = cos(dataa), 1 = read last result, 2 = read op count, 3 = read error count
dataa  in  W  float argument (opcode 0 only)
done  out  1  one-cycle completion pulse (registered)
result  out  W  registered result, valid while done=1 and held afterwards
cordic_dataa  out  W  float argument to the core (sign bit always 0)
cordic_result  in  W  float cos from the core

Behaviour:
- Reset (rst=0, async): state=IDLE, done=0, result=0, cordic_dataa=0, last_q=0, op_cnt=0, err_cnt=0, wait counter=0.
- Timing notation: cycle 0 is the cycle in which start=1 and clk_en=1 are sampled.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on start & clk_en, decode n.
    - n=0, in range: cordic_dataa <= {1'b0, dataa[30:0]}; counter <= LATENCY; go to WAIT.
    - n=0, out of range: result <= 32'h7FC00000; err_cnt++; go to DONE.
    - n=1: result <= last_q. n=2: result <= op_cnt. n=3: result <= err_cnt. All go to DONE.
  - WAIT: decrement the counter each enabled cycle. When it reaches 1: result <= cordic_result; last_q <= cordic_result; op_cnt++; go to DONE.
  - DONE: done=1 for exactly one enabled cycle, then go to IDLE.
- Latency:
  - In-range cos: done high in cycle LATENCY+1 (cycle 5 by default).
  - Error and all read-backs: done high in cycle 1.
- Range rule, on |a| (exp = dataa[30:23], mant = dataa[22:0]):
  - Reject if exp > 127, or exp = 127 and mant > 23'h490FDB (|a| > 1.5707963).
  - 8'hFF exponents (Inf/NaN) are therefore rejected.
  - Zero and denormals are accepted.
- cordic_dataa holds constant from the end of cycle 0 until the next accepted cos. It is never changed by read-backs or errors.
- clk_en low: all state, counters, done and result freeze. Because cordic_dataa is held, the result stays valid, and done is delayed one cycle per stalled cycle.
- start while not IDLE: ignored (the CPU protocol forbids it); no counter changes.
- Counters wrap modulo 2^CNT_W. A rejected op increments only err_cnt.
- Reset mid-operation: abort immediately; no done pulse; return to IDLE with reset values.
- done is never high on two consecutive enabled cycles.

Decomposition:
- Shared package (cordic_pkg):
  - opcodes OP_COS=0, OP_LAST=1, OP_OPCNT=2, OP_ERRCNT=3
  - QNAN=32'h7FC00000
  - HALF_PI_EXP=8'd127, HALF_PI_MANT=23'h490FDB
  - FSM state enum
  - default LATENCY
- Sub-module: cordic_arg_check, a combinational range check on |a| returning in_range. It is reused by future sin/tan front ends.

Test Plan:
1. Reset, then idle 3 cycles -> done=0, result=0, cordic_dataa=0, and n=2/n=3 reads return 0.
2. Core model returns 32'h3F800000 with LATENCY=4; start n=0, dataa=32'h00000000 -> done in cycle 5, result=32'h3F800000; then n=1 read -> result=32'h3F800000 in cycle 1.
3. dataa=32'hBF000000 (-0.5) -> cordic_dataa=32'h3F000000. dataa=32'h3FC90FDB -> accepted, done in cycle 5. dataa=32'h3FC90FDC -> done in cycle 1, result=32'h7FC00000, err_cnt=1.
4. dataa=32'h7F800000 (Inf) and 32'h40000000 -> both return 32'h7FC00000; then n=3 -> result=2, n=2 -> unchanged.
5. In-range cos with clk_en low for 3 cycles during WAIT -> done in cycle 8; result and cordic_dataa stable throughout.
6. rst pulsed low in cycle 2 of a cos op -> no done pulse, counters 0; a following op completes normally in cycle 5.
